// File: rtl/audio_lpf_pkg.sv
// Shared constants, state encoding and Q-format helper for the audio
// low-pass decimator.
package audio_lpf_pkg;

  localparam int TAPS       = 32;
  localparam int DECIM      = 8;
  localparam int BITS       = 10;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  // Q10 low-pass taps; index 0 multiplies the newest sample.
  localparam logic signed [31:0] COEFFS [TAPS] = '{
    32'sd500, -32'sd12, -32'sd20, -32'sd25, -32'sd18,  32'sd5,   32'sd40,  32'sd80,
    32'sd120,  32'sd170, 32'sd220, 32'sd270, 32'sd310, 32'sd340, 32'sd360, 32'sd370,
    32'sd370,  32'sd360, 32'sd340, 32'sd310, 32'sd270, 32'sd220, 32'sd170, 32'sd120,
    32'sd80,   32'sd40,  32'sd5,  -32'sd18, -32'sd25, -32'sd20, -32'sd12,  32'sd500
  };

  // Divide by 2^bits rounding toward zero, then keep the low 32 bits.
  function automatic logic signed [31:0] deq(input logic signed [63:0] p,
                                            input int                  bits);
    logic signed [63:0] m;
    if (p < 0) m = -((-p) >>> bits);
    else       m = p >>> bits;
    return m[31:0];
  endfunction

endpackage

// File: rtl/audio_lpf_decim.sv
// FIR low-pass plus decimate-by-DECIM: pops DECIM samples from a show-ahead
// FIFO, runs one MAC per tap, then pushes one result downstream.
module audio_lpf_decim #(
  parameter int TAPS       = audio_lpf_pkg::TAPS,
  parameter int DECIM      = audio_lpf_pkg::DECIM,
  parameter int BITS       = audio_lpf_pkg::BITS,
  parameter int DATA_WIDTH = audio_lpf_pkg::DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] in_dout,
  input  logic                         in_empty,
  output logic                         in_rd_en,
  output logic signed [DATA_WIDTH-1:0] out_din,
  input  logic                         out_full,
  output logic                         out_wr_en
);
  import audio_lpf_pkg::*;

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TAP_W = (TAPS > 1)  ? $clog2(TAPS)  : 1;

  state_e                             state_q, state_d;
  logic [TAPS-1:0][DATA_WIDTH-1:0]    x_q, x_d;
  logic signed [DATA_WIDTH-1:0]       acc_q, acc_d;
  logic [TAP_W-1:0]                   tap_q, tap_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               pop, push;
  logic signed [63:0]                 prod;
  logic signed [DATA_WIDTH-1:0]       term;

  assign prod = 64'(COEFFS[tap_q]) * 64'($signed(x_q[tap_q]));
  assign term = DATA_WIDTH'(deq(prod, BITS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      x_q     <= '0;
      acc_q   <= '0;
      tap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (!in_empty) begin
          pop = 1'b1;
          x_d = {x_q[TAPS-2:0], in_dout};
          if (cnt_q == CNT_W'(DECIM-1)) begin
            cnt_d   = '0;
            acc_d   = '0;
            state_d = S_MAC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + term;
        if (tap_q == TAP_W'(TAPS-1)) begin
          tap_d   = '0;
          state_d = S_WRITE;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (!out_full) begin
          push    = 1'b1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Gate the pop with reset so nothing is consumed while reset is held.
  assign in_rd_en  = pop & reset;
  assign out_wr_en = push;
  assign out_din   = acc_q;

endmodule
